sqrt_batch_sequencer: RTL and testbench

//  Batch controller for the square-root datapath. Walks the operand RAM from address 0 to LAST,

---
 rtl/sqrt_seq_pkg.sv | 22 ++
 rtl/sqrt_batch_sequencer_if.sv | 22 ++
 rtl/sqrt_seq_watchdog.sv | 41 ++++
 rtl/sqrt_batch_sequencer.sv | 156 +++++++++++++++
 tb/tb_sqrt_batch_sequencer.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_seq_pkg.sv
// Shared types and defaults for the square-root batch sequencer.
// Provides the FSM state enum, default widths and the watchdog width.
package sqrt_seq_pkg;

    localparam int ADDR_W_DEF  = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 255;
    localparam int WD_W        = 10;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        WAIT_HI,
        STORE,
        WAIT_LO,
        FINISH,
        ERROR
    } state_e;

endpackage

// File: rtl/sqrt_batch_sequencer_if.sv
// St/Done handshake bundle between the sequencer and the square-root unit.
// master: sq_n, sq_st out / sq_done, sq_root in.  slave: the reverse.
interface sqrt_batch_sequencer_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] sq_n;
    logic              sq_st;
    logic              sq_done;
    logic [DATA_W-1:0] sq_root;

    modport master (
        output sq_n, sq_st,
        input  sq_done, sq_root
    );

    modport slave (
        input  sq_n, sq_st,
        output sq_done, sq_root
    );

endinterface

// File: rtl/sqrt_seq_watchdog.sv
// Cycle watchdog for the handshake wait states.
// clk/resetN, clr (zero the count), en (count), expired (TIMEOUT cycles spent).
module sqrt_seq_watchdog
    import sqrt_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic resetN,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WD_W-1:0] LIM = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] cnt_q;
    logic [WD_W-1:0] cnt_d;

    // Saturates at LIM so a long stall cannot wrap back below it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != LIM) begin
            cnt_d = cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count 0 is the first waiting cycle, so LIM marks the TIMEOUT-th.
    assign expired = en && (cnt_q == LIM);

endmodule

// File: rtl/sqrt_batch_sequencer.sv
// Walks the operand RAM 0..LAST, runs the square-root St/Done handshake
// per operand and writes {operand, root} to the result buffer.
// Ports: clk, resetN, start, stop, mem_addr/mem_data (RAM), sq (unit
// handshake), res_wr/res_addr/res_data, busy, batch_done, count, err.
module sqrt_batch_sequencer
    import sqrt_seq_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  start,
    input  logic                  stop,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_data,
    sqrt_batch_sequencer_if.master sq,
    output logic                  res_wr,
    output logic [ADDR_W-1:0]     res_addr,
    output logic [2*DATA_W-1:0]   res_data,
    output logic                  busy,
    output logic                  batch_done,
    output logic [ADDR_W:0]       count,
    output logic                  err
);

    localparam logic [ADDR_W-1:0] LAST    = '1;
    localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   sq_n_q, sq_n_d;
    logic                sq_st_q, sq_st_d;
    logic [2*DATA_W-1:0] res_q, res_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                bdone_q, bdone_d;

    logic idle_like;
    logic launch;
    logic wd_clr;
    logic wd_en;
    logic wd_exp;

    assign idle_like = (state_q == IDLE) || (state_q == FINISH) ||
                       (state_q == ERROR);
    assign launch    = idle_like && start;
    assign wd_clr    = (state_q == START) || (state_q == STORE);
    assign wd_en     = (state_q == WAIT_HI) || (state_q == WAIT_LO);

    sqrt_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .resetN  (resetN),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_exp)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sq_n_q  <= '0;
            sq_st_q <= 1'b0;
            res_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            bdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sq_n_q  <= sq_n_d;
            sq_st_q <= sq_st_d;
            res_q   <= res_d;
            count_q <= count_d;
            err_q   <= err_d;
            bdone_q <= bdone_d;
        end
    end

    // Completion has priority over a watchdog expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, FINISH, ERROR: if (start) state_d = FETCH;
            FETCH:   state_d = LOAD;
            LOAD:    state_d = START;
            START:   state_d = WAIT_HI;
            WAIT_HI: begin
                if (sq.sq_done)  state_d = STORE;
                else if (wd_exp) state_d = ERROR;
            end
            STORE:   state_d = WAIT_LO;
            WAIT_LO: begin
                if (!sq.sq_done) begin
                    if (addr_q == LAST || stop) state_d = FINISH;
                    else                        state_d = FETCH;
                end else if (wd_exp) begin
                    state_d = ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        sq_n_d  = sq_n_q;
        sq_st_d = sq_st_q;
        res_d   = res_q;
        count_d = count_q;
        err_d   = err_q;
        bdone_d = (state_d == FINISH) && (state_q != FINISH);
        if (launch) begin
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end
        if (state_d == ERROR && state_q != ERROR) begin
            err_d   = 1'b1;
            sq_st_d = 1'b0;
        end
        unique case (state_q)
            LOAD:    sq_n_d = mem_data;
            START:   sq_st_d = 1'b1;
            WAIT_HI: begin
                if (sq.sq_done) begin
                    res_d   = {sq_n_q, sq.sq_root};
                    sq_st_d = 1'b0;
                end
            end
            STORE: begin
                if (count_q != CNT_MAX) count_d = count_q + (ADDR_W+1)'(1);
            end
            WAIT_LO: begin
                if (state_d == FETCH) addr_d = addr_q + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    assign mem_addr   = addr_q;
    assign sq.sq_n    = sq_n_q;
    assign sq.sq_st   = sq_st_q;
    assign res_wr     = (state_q == STORE);
    assign res_addr   = addr_q;
    assign res_data   = res_q;
    assign busy       = !idle_like;
    assign batch_done = bdone_q;
    assign count      = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sqrt_batch_sequencer.sv
// Bench for sqrt_batch_sequencer: registered RAM model, behavioural
// square-root unit with programmable latency/hold, result scoreboard.
module tb_sqrt_batch_sequencer;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 8;
    localparam int N  = 16;
    localparam logic [DW-1:0] SPEC_RAM [N] = '{
        8'd0, 8'd1, 8'd4, 8'd9, 8'd16, 8'd25, 8'd36, 8'd49,
        8'd64, 8'd0, 8'd6, 8'd13, 8'd21, 8'd27, 8'd44, 8'd255};

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data = '0;
    logic            res_wr;
    logic [AW-1:0]   res_addr;
    logic [2*DW-1:0] res_data;
    logic            busy;
    logic            batch_done;
    logic [AW:0]     count;
    logic            err;

    int n_cmp = 0;
    int n_err = 0;

    sqrt_batch_sequencer_if #(.DATA_W(DW)) sif ();

    sqrt_batch_sequencer #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .start     (start),
        .stop      (stop),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .sq        (sif),
        .res_wr    (res_wr),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .busy      (busy),
        .batch_done(batch_done),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [N];

    always @(posedge clk) mem_data <= ram[mem_addr];

    function automatic logic [DW-1:0] isqrt(input logic [DW-1:0] n);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(n)) r++;
        return DW'(r);
    endfunction

    function automatic logic [2*DW-1:0] exp_word(input int a);
        return {ram[a], isqrt(ram[a])};
    endfunction

    // Behavioural square-root unit.
    int u_lat = 0;
    int u_hold = 1;
    bit u_never = 0;
    int u_st = 0;
    int u_cnt = 0;

    always @(posedge clk) begin
        if (!resetN) begin
            u_st <= 0;
            u_cnt <= 0;
            sif.sq_done <= 1'b0;
            sif.sq_root <= '0;
        end else begin
            case (u_st)
                0: if (sif.sq_st && !u_never) begin
                    if (u_lat == 0) begin
                        sif.sq_done <= 1'b1;
                        sif.sq_root <= isqrt(sif.sq_n);
                        u_cnt <= u_hold - 1;
                        u_st <= 2;
                    end else begin
                        u_cnt <= u_lat - 1;
                        u_st <= 1;
                    end
                end
                1: if (u_cnt == 0) begin
                    sif.sq_done <= 1'b1;
                    sif.sq_root <= isqrt(sif.sq_n);
                    u_cnt <= u_hold - 1;
                    u_st <= 2;
                end else begin
                    u_cnt <= u_cnt - 1;
                end
                2: if (u_cnt == 0) begin
                    sif.sq_done <= 1'b0;
                    u_st <= 3;
                end else begin
                    u_cnt <= u_cnt - 1;
                end
                default: if (!sif.sq_st) u_st <= 0;
            endcase
        end
    end

    // Scoreboard monitor.
    logic [AW-1:0]   wq_a [$];
    logic [2*DW-1:0] wq_d [$];
    int bd_cnt = 0;
    int pulse_id = 0;
    int wr_pulse = -1;
    int dup = 0;
    int early = 0;
    logic done_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;

    always @(negedge clk) begin
        if (resetN) begin
            if (res_wr) begin
                wq_a.push_back(res_addr);
                wq_d.push_back(res_data);
                if (wr_pulse == pulse_id) dup++;
                wr_pulse = pulse_id;
            end
            if (batch_done) bd_cnt++;
            if (mem_addr != addr_prev && mem_addr != '0 && done_prev)
                early++;
            if (sif.sq_done && !done_prev) pulse_id++;
        end
        done_prev = sif.sq_done;
        addr_prev = mem_addr;
    end

    task automatic clear_sb();
        wq_a.delete();
        wq_d.delete();
        bd_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_bdone(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (batch_done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic launch_and_wait(output bit ok);
        clear_sb();
        pulse_start();
        wait_bdone(1000, ok);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_addr, sif.sq_n, sif.sq_st, res_wr, res_addr, res_data,
             busy, batch_done, count, err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got addr=%0d n=%0d st=%0b wr=%0b data=%h busy=%0b bd=%0b cnt=%0d err=%0b, want all 0",
                     mem_addr, sif.sq_n, sif.sq_st, res_wr, res_data,
                     busy, batch_done, count, err);
        end
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy: got %0b want 0", busy);
        end
    endtask

    task automatic test_full_batch();
        bit ok;
        ram = SPEC_RAM;
        u_lat = 0; u_hold = 1; u_never = 0;
        launch_and_wait(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL full_timeout: batch_done not seen, want within 1000 cycles");
        end
        n_cmp++;
        if (wq_a.size() != N) begin
            n_err++;
            $display("FAIL full_nwrites: got %0d want %0d", wq_a.size(), N);
        end
        for (int i = 0; i < wq_a.size() && i < N; i++) begin
            n_cmp++;
            if (wq_a[i] !== AW'(i) || wq_d[i] !== exp_word(i)) begin
                n_err++;
                $display("FAIL full_write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                         i, wq_a[i], wq_d[i], i, exp_word(i));
            end
        end
        if (wq_d.size() == N) begin
            n_cmp++;
            if (wq_d[14] !== 16'h2C06 || wq_d[15] !== 16'hFF0F) begin
                n_err++;
                $display("FAIL full_spec_words: got %h %h want 2c06 ff0f",
                         wq_d[14], wq_d[15]);
            end
        end
        n_cmp++;
        if (count !== 5'd16 || bd_cnt != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL full_end: got count=%0d bd=%0d busy=%0b want 16 1 0",
                     count, bd_cnt, busy);
        end
    endtask

    task automatic test_random_batches();
        bit ok;
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < N; a++) ram[a] = DW'($urandom_range(0, 255));
            u_lat = $urandom_range(0, 3);
            u_hold = $urandom_range(1, 3);
            launch_and_wait(ok);
            n_cmp++;
            if (!ok || wq_a.size() != N || count !== 5'd16) begin
                n_err++;
                $display("FAIL rand%0d_end: got ok=%0b writes=%0d count=%0d want 1 16 16",
                         r, ok, wq_a.size(), count);
            end
            for (int i = 0; i < wq_a.size() && i < N; i++) begin
                n_cmp++;
                if (wq_a[i] !== AW'(i) || wq_d[i] !== exp_word(i)) begin
                    n_err++;
                    $display("FAIL rand%0d_write%0d: got %0d/%h want %0d/%h",
                             r, i, wq_a[i], wq_d[i], i, exp_word(i));
                end
            end
        end
    endtask

    task automatic test_hold_done();
        bit ok;
        int dup0, early0;
        dup0 = dup; early0 = early;
        u_lat = 1; u_hold = 5;
        launch_and_wait(ok);
        n_cmp++;
        if (!ok || wq_a.size() != N) begin
            n_err++;
            $display("FAIL hold_writes: got ok=%0b writes=%0d want 1 16", ok, wq_a.size());
        end
        n_cmp++;
        if (dup != dup0 || early != early0) begin
            n_err++;
            $display("FAIL hold_handshake: got dup=%0d early=%0d want 0 0",
                     dup - dup0, early - early0);
        end
        for (int i = 0; i < wq_a.size() && i < N; i++) begin
            n_cmp++;
            if (wq_a[i] !== AW'(i) || wq_d[i] !== exp_word(i)) begin
                n_err++;
                $display("FAIL hold_write%0d: got %0d/%h want %0d/%h",
                         i, wq_a[i], wq_d[i], i, exp_word(i));
            end
        end
        u_hold = 1;
    endtask

    task automatic test_stop();
        bit ok;
        bit hit;
        u_lat = 1; u_hold = 1;
        clear_sb();
        pulse_start();
        hit = 0;
        for (int i = 0; i < 400; i++) begin
            if (mem_addr == AW'(3) && sif.sq_st) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        stop = 1'b1;
        wait_bdone(200, ok);
        stop = 1'b0;
        n_cmp++;
        if (!hit || !ok) begin
            n_err++;
            $display("FAIL stop_progress: got reached3=%0b done=%0b want 1 1", hit, ok);
        end
        n_cmp++;
        if (wq_a.size() != 4 || count !== 5'd4 || mem_addr !== AW'(3) || bd_cnt != 1) begin
            n_err++;
            $display("FAIL stop_end: got writes=%0d count=%0d addr=%0d bd=%0d want 4 4 3 1",
                     wq_a.size(), count, mem_addr, bd_cnt);
        end
        for (int i = 0; i < wq_a.size() && i < 4; i++) begin
            n_cmp++;
            if (wq_a[i] !== AW'(i) || wq_d[i] !== exp_word(i)) begin
                n_err++;
                $display("FAIL stop_write%0d: got %0d/%h want %0d/%h",
                         i, wq_a[i], wq_d[i], i, exp_word(i));
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        bit hit;
        int k;
        u_never = 1;
        clear_sb();
        pulse_start();
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            if (sif.sq_st) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        k = 0;
        while (k < 30 && err !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!hit || k < 1 || k > 9) begin
            n_err++;
            $display("FAIL to_latency: got st_seen=%0b cycles=%0d want 1 and 1..9", hit, k);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || sif.sq_st !== 1'b0 || busy !== 1'b0 || wq_a.size() != 0) begin
            n_err++;
            $display("FAIL to_error_state: got err=%0b st=%0b busy=%0b writes=%0d want 1 0 0 0",
                     err, sif.sq_st, busy, wq_a.size());
        end
        u_never = 0;
        clear_sb();
        pulse_start();
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL to_restart: got err=%0b busy=%0b want 0 1", err, busy);
        end
        wait_bdone(1000, ok);
        n_cmp++;
        if (!ok || wq_a.size() != N || err !== 1'b0) begin
            n_err++;
            $display("FAIL to_rerun: got ok=%0b writes=%0d err=%0b want 1 16 0",
                     ok, wq_a.size(), err);
        end
    endtask

    task automatic test_reset_midway();
        bit ok;
        bit hit;
        u_lat = 0; u_hold = 1;
        clear_sb();
        pulse_start();
        hit = 0;
        for (int i = 0; i < 400; i++) begin
            if (mem_addr == AW'(7) && sif.sq_st) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        resetN = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (!hit || {mem_addr, sif.sq_n, sif.sq_st, res_wr, res_addr, res_data,
                     busy, batch_done, count, err} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got hit=%0b addr=%0d st=%0b wr=%0b busy=%0b cnt=%0d want hit=1 all 0",
                     hit, mem_addr, sif.sq_st, res_wr, busy, count);
        end
        @(negedge clk);
        resetN = 1'b1;
        n_cmp++;
        if (wq_a.size() != 7) begin
            n_err++;
            $display("FAIL midreset_writes: got %0d want 7", wq_a.size());
        end
        launch_and_wait(ok);
        n_cmp++;
        if (!ok || wq_a.size() != N || count !== 5'd16) begin
            n_err++;
            $display("FAIL midreset_rerun: got ok=%0b writes=%0d count=%0d want 1 16 16",
                     ok, wq_a.size(), count);
        end
        if (wq_a.size() > 0) begin
            n_cmp++;
            if (wq_a[0] !== '0 || wq_d[0] !== exp_word(0)) begin
                n_err++;
                $display("FAIL midreset_first: got %0d/%h want 0/%h",
                         wq_a[0], wq_d[0], exp_word(0));
            end
        end
    endtask

    task automatic test_busy_start();
        bit ok;
        u_lat = 1; u_hold = 2;
        clear_sb();
        pulse_start();
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (batch_done) begin
                start = 1'b0;
                ok = 1;
                break;
            end
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (!ok || wq_a.size() != N || count !== 5'd16 || bd_cnt != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_start_end: got ok=%0b writes=%0d count=%0d bd=%0d busy=%0b want 1 16 16 1 0",
                     ok, wq_a.size(), count, bd_cnt, busy);
        end
        for (int i = 0; i < wq_a.size() && i < N; i++) begin
            n_cmp++;
            if (wq_a[i] !== AW'(i) || wq_d[i] !== exp_word(i)) begin
                n_err++;
                $display("FAIL busy_start_write%0d: got %0d/%h want %0d/%h",
                         i, wq_a[i], wq_d[i], i, exp_word(i));
            end
        end
    endtask

    initial begin
        ram = SPEC_RAM;
        test_reset();
        test_full_batch();
        test_random_batches();
        test_hold_done();
        test_stop();
        test_timeout();
        test_reset_midway();
        test_busy_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 500000");
        $fatal(1);
    end

endmodule
